// File: rtl/lsq_index_recycler.sv
// lsq_index_recycler: stages commit-freed LSQ indices and pushes one per cycle into the free-index queue.
// Define LSQ_RECYCLE_BYPASS_EN to forward a lone slot-A index straight to CriqDin when staging is empty.
module lsq_index_recycler #(
    parameter int IDXWIDE   = 4,
    parameter int STAGEDEEP = 4
) (
    input  logic                         Clk,
    input  logic                         Rest,
    input  logic                         RetAValid,
    input  logic [IDXWIDE-1:0]           RetAIdx,
    input  logic                         RetBValid,
    input  logic [IDXWIDE-1:0]           RetBIdx,
    output logic                         RetReady,
    input  logic                         CriqFull,
    output logic                         CriqWable,
    output logic [IDXWIDE-1:0]           CriqDin,
    input  logic                         FlushReq,
    output logic                         CriqClean,
    output logic [$clog2(STAGEDEEP):0]   StageCount,
    output logic                         RecyclerEmpty
);
    localparam int PW = $clog2(STAGEDEEP);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

    state_t             state_q, state_d;
    logic [IDXWIDE-1:0] mem_q [STAGEDEEP];
    logic [PW-1:0]      rd_q, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               clean_q;
    logic               run, byp, pop, wa, wb;

    assign run      = state_q == RUN && !FlushReq;
    assign RetReady = run && (CW'(STAGEDEEP) - cnt_q >= CW'(2));
`ifdef LSQ_RECYCLE_BYPASS_EN
    assign byp = run && cnt_q == '0 && RetAValid && !RetBValid && !CriqFull;
`else
    assign byp = 1'b0;
`endif
    assign pop           = run && cnt_q != '0 && !CriqFull;
    assign CriqWable     = pop || byp;
    assign CriqDin       = byp ? RetAIdx : mem_q[rd_q];
    assign wa            = RetReady && RetAValid && !byp;
    assign wb            = RetReady && RetBValid;
    assign CriqClean     = clean_q;
    assign StageCount    = cnt_q;
    assign RecyclerEmpty = cnt_q == '0;
    assign state_d       = state_q == FLUSH ? HOLD : FlushReq ? FLUSH : RUN;
    assign wr_d          = wr_q + PW'(wa) + PW'(wb);
    assign cnt_d         = cnt_q + CW'(wa) + CW'(wb) - CW'(pop);

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            state_q <= RUN;
            clean_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < STAGEDEEP; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= state_d == FLUSH;
            if (state_q == FLUSH) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (wa) mem_q[wr_q] <= RetAIdx;
                if (wb) mem_q[wr_q + PW'(wa)] <= RetBIdx;
                wr_q  <= wr_d;
                rd_q  <= rd_q + PW'(pop);
                cnt_q <= cnt_d;
            end
        end
    end
endmodule
